// File: rtl/comp_seq_pkg.sv
// Shared types and default sizing for the comparator sequencer.
package comp_seq_pkg;

  localparam int N_CHAN_DEF   = 4;
  localparam int CAL_BITS_DEF = 5;
  localparam int CAL_AVG_DEF  = 7;
  localparam int META_TO_DEF  = 6;
  localparam int RST_CYC_DEF  = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int CHAN_W = $clog2(N_CHAN_DEF);
  // Wide enough to hold the largest of the eval, reset and vote counts.
  localparam int CNT_W  = $clog2(max3(META_TO_DEF, RST_CYC_DEF, CAL_AVG_DEF) + 1);

  typedef enum logic [1:0] {IDLE, EVAL, RESET, DONE} state_t;

endpackage

// File: rtl/comp_sync2.sv
// Two-flop synchroniser; resets high to match precharged comparator outputs.
module comp_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1, r_s2;

  // Two-stage capture of the asynchronous comparator outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/comp_seq.sv
// Comparator sequencer: eval/reset clocking, decision resolve, metastability
// timeout and majority-voted binary-search offset calibration.
module comp_seq
  import comp_seq_pkg::*;
#(
  parameter int N_CHAN   = N_CHAN_DEF,
  parameter int CAL_BITS = CAL_BITS_DEF,
  parameter int CAL_AVG  = CAL_AVG_DEF,
  parameter int META_TO  = META_TO_DEF,
  parameter int RST_CYC  = RST_CYC_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         cal_mode,
  input  logic [$clog2(N_CHAN)-1:0]    chan_sel,
  output logic [N_CHAN-1:0]            comp_clk,
  output logic [N_CHAN-1:0]            comp_clkb,
  input  logic [N_CHAN-1:0]            comp_outp,
  input  logic [N_CHAN-1:0]            comp_outn,
  output logic [N_CHAN*CAL_BITS-1:0]   trim,
  output logic                         busy,
  output logic                         dec_valid,
  output logic                         dec,
  output logic                         meta,
  output logic                         cal_done
);

  localparam int CW  = $clog2(N_CHAN);
  localparam int CTW = $clog2(max3(META_TO, RST_CYC, CAL_AVG) + 1);
  localparam int BW  = $clog2(CAL_BITS);
  localparam logic [CAL_BITS-1:0] MID = CAL_BITS'(1 << (CAL_BITS - 1));

  state_t                           r_state;
  logic [CW-1:0]                    r_chan;
  logic                             r_cal;
  logic [CTW-1:0]                   r_cnt, r_votes, r_ones;
  logic [BW-1:0]                    r_bit;
  logic                             r_dec_i, r_meta_i;
  logic [N_CHAN-1:0][CAL_BITS-1:0]  r_trim;
  logic [N_CHAN-1:0]                r_comp_clk, r_comp_clkb;
  logic                             r_busy, r_dec_valid, r_dec, r_meta, r_cal_done;

  logic [2*N_CHAN-1:0] w_sync;
  logic [N_CHAN-1:0]   w_syn_p, w_syn_n, w_oh_cur, w_oh_new;
  logic [CW-1:0]       w_chan_cl;
  logic                w_res, w_bit_dec, w_keep;
  logic [CTW-1:0]      w_ones_n, w_votes_n;

  comp_sync2 #(.W(2 * N_CHAN)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({comp_outn, comp_outp}),
    .o_q   (w_sync)
  );

  // Channel clamp, decision resolve and calibration vote arithmetic
  always_comb begin
    w_syn_p   = w_sync[N_CHAN-1:0];
    w_syn_n   = w_sync[2*N_CHAN-1:N_CHAN];
    w_chan_cl = (int'(chan_sel) > N_CHAN - 1) ? CW'(N_CHAN - 1) : chan_sel;
    // Exactly one side low resolves; both low is illegal and treated as pending.
    w_res     = w_syn_p[r_chan] ^ w_syn_n[r_chan];
    w_bit_dec = w_syn_p[r_chan] & ~w_syn_n[r_chan];
    w_ones_n  = r_ones + CTW'(r_dec_i);
    w_votes_n = r_votes + 1'b1;
    w_keep    = (w_ones_n > CTW'(CAL_AVG / 2));
    w_oh_cur  = N_CHAN'(1) << r_chan;
    w_oh_new  = N_CHAN'(1) << w_chan_cl;
  end

  // Sequencer FSM with registered clocks, flags and trim codes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_chan      <= '0;
      r_cal       <= 1'b0;
      r_cnt       <= '0;
      r_votes     <= '0;
      r_ones      <= '0;
      r_bit       <= '0;
      r_dec_i     <= 1'b0;
      r_meta_i    <= 1'b0;
      for (int i = 0; i < N_CHAN; i++) r_trim[i] <= MID;
      r_comp_clk  <= '0;
      r_comp_clkb <= '1;
      r_busy      <= 1'b0;
      r_dec_valid <= 1'b0;
      r_dec       <= 1'b0;
      r_meta      <= 1'b0;
      r_cal_done  <= 1'b0;
    end else begin
      r_dec_valid <= 1'b0;
      r_cal_done  <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_chan      <= w_chan_cl;
          r_cal       <= cal_mode;
          r_busy      <= 1'b1;
          r_cnt       <= '0;
          r_comp_clk  <= w_oh_new;
          r_comp_clkb <= ~w_oh_new;
          r_state     <= EVAL;
          if (cal_mode) begin
            r_trim[w_chan_cl] <= MID;
            r_bit   <= BW'(CAL_BITS - 1);
            r_votes <= '0;
            r_ones  <= '0;
          end
        end
        EVAL: begin
          if (w_res || r_cnt == CTW'(META_TO - 1)) begin
            // A timeout forces a 0 decision so calibration votes stay defined.
            r_dec_i     <= w_res & w_bit_dec;
            r_meta_i    <= ~w_res;
            r_comp_clk  <= '0;
            r_comp_clkb <= '1;
            r_cnt       <= '0;
            r_state     <= RESET;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESET: begin
          if (r_cnt == CTW'(RST_CYC - 1)) begin
            r_cnt <= '0;
            if (!r_cal) begin
              r_dec_valid <= 1'b1;
              r_dec       <= r_dec_i;
              r_meta      <= r_meta_i;
              r_state     <= DONE;
            end else if (w_votes_n < CTW'(CAL_AVG)) begin
              r_ones      <= w_ones_n;
              r_votes     <= w_votes_n;
              r_comp_clk  <= w_oh_cur;
              r_comp_clkb <= ~w_oh_cur;
              r_state     <= EVAL;
            end else begin
              if (!w_keep) r_trim[r_chan][r_bit] <= 1'b0;
              if (r_bit != '0) begin
                r_trim[r_chan][r_bit - 1'b1] <= 1'b1;
                r_bit       <= r_bit - 1'b1;
                r_ones      <= '0;
                r_votes     <= '0;
                r_comp_clk  <= w_oh_cur;
                r_comp_clkb <= ~w_oh_cur;
                r_state     <= EVAL;
              end else begin
                r_cal_done <= 1'b1;
                r_state    <= DONE;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign comp_clk  = r_comp_clk;
  assign comp_clkb = r_comp_clkb;
  assign trim      = r_trim;
  assign busy      = r_busy;
  assign dec_valid = r_dec_valid;
  assign dec       = r_dec;
  assign meta      = r_meta;
  assign cal_done  = r_cal_done;

endmodule

// File: tb/tb_comp_seq.sv
// Self-checking bench for comp_seq: vector table, random normal-mode runs,
// calibration searches against a behavioural model, reset and busy corners.
module tb_comp_seq;
  import comp_seq_pkg::*;

  localparam int NC = 4, CB = 5, CA = 7, MT = 6, RC = 2;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cal_mode = 1'b0;
  logic [1:0] chan_sel = '0;
  logic [NC-1:0] comp_clk, comp_clkb, comp_outp, comp_outn;
  logic [NC*CB-1:0] trim;
  logic busy, dec_valid, dec, meta, cal_done;

  comp_seq #(.N_CHAN(NC), .CAL_BITS(CB), .CAL_AVG(CA), .META_TO(MT), .RST_CYC(RC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cal_mode(cal_mode), .chan_sel(chan_sel),
    .comp_clk(comp_clk), .comp_clkb(comp_clkb), .comp_outp(comp_outp), .comp_outn(comp_outn),
    .trim(trim), .busy(busy), .dec_valid(dec_valid), .dec(dec), .meta(meta), .cal_done(cal_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  // Comparator behaviour per channel: 0/1 fixed decision, 2 never resolves,
  // 3 both outputs low, 4 offset threshold on trim, 5 scripted vote pattern.
  int beh [NC];
  int thr = 19;
  logic [63:0] pat = '0;
  int pat_base = 0;
  int n_eval = 0, dv_cnt = 0, cd_cnt = 0;
  logic [NC-1:0] prev_clk = '0;

  always @(posedge clk) begin
    prev_clk <= comp_clk;
    if ((prev_clk & ~comp_clk) != '0) n_eval <= n_eval + 1;
  end

  always @(negedge clk) begin
    if (dec_valid) dv_cnt <= dv_cnt + 1;
    if (cal_done)  cd_cnt <= cd_cnt + 1;
  end

  always_comb begin
    comp_outp = '1;
    comp_outn = '1;
    for (int c = 0; c < NC; c++) begin
      if (comp_clk[c]) begin
        case (beh[c])
          0: begin comp_outp[c] = 1'b0; comp_outn[c] = 1'b1; end
          1: begin comp_outp[c] = 1'b1; comp_outn[c] = 1'b0; end
          3: begin comp_outp[c] = 1'b0; comp_outn[c] = 1'b0; end
          4: begin
            comp_outp[c] = (int'(trim[c*CB +: CB]) < thr);
            comp_outn[c] = ~comp_outp[c];
          end
          5: begin
            comp_outp[c] = pat[(n_eval - pat_base) & 63];
            comp_outn[c] = ~comp_outp[c];
          end
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Decision the comparator yields for one evaluation, per its behaviour.
  function automatic int cmp_model(input int b, input int code, input int idx);
    case (b)
      1: return 1;
      4: return (code >= thr) ? 0 : 1;
      5: return int'(pat[idx & 63]);
      default: return 0;
    endcase
  endfunction

  // Binary search: try each bit from MSB down, keep it on a strict majority of ones.
  function automatic int cal_model(input int b);
    int code = 0, idx = 0;
    for (int bt = CB - 1; bt >= 0; bt--) begin
      int trial = code | (1 << bt);
      int ones = 0;
      for (int v = 0; v < CA; v++) begin
        ones += cmp_model(b, trial, idx);
        idx++;
      end
      if (2 * ones > CA) code = trial;
    end
    return code;
  endfunction

  task automatic run_normal(input int ch, input int b, input logic edec, input logic emeta,
                            input int elat, input int ehi);
    int lat, hi;
    logic bad;
    logic [NC-1:0] sel;
    sel = '0; sel[ch] = 1'b1;
    beh[ch] = b;
    @(negedge clk); start = 1'b1; cal_mode = 1'b0; chan_sel = 2'(ch);
    @(negedge clk); start = 1'b0;
    lat = 1; hi = 0; bad = 1'b0;
    while (!dec_valid && lat < 60) begin
      if (comp_clk[ch]) hi++;
      if ((comp_clk & ~sel) != '0 || comp_clkb !== ~comp_clk) bad = 1'b1;
      @(negedge clk); lat++;
    end
    chk($sformatf("dv_seen ch%0d", ch), dec_valid, 1);
    chk($sformatf("latency ch%0d b%0d", ch, b), lat, elat);
    chk($sformatf("eval_cycles ch%0d b%0d", ch, b), hi, ehi);
    chk($sformatf("other_chan_quiet ch%0d", ch), bad, 0);
    chk($sformatf("dec ch%0d b%0d", ch, b), dec, edec);
    chk($sformatf("meta ch%0d b%0d", ch, b), meta, emeta);
    chk("busy_in_done", busy, 1);
    @(negedge clk);
    chk("dv_one_cycle", dec_valid, 0);
    chk("busy_after_done", busy, 0);
    chk("dec_held", dec, edec);
  endtask

  task automatic run_cal(input int ch, input int b, input int exp_trim);
    logic [NC*CB-1:0] snap;
    logic sdec, smeta;
    int base, dv0, cyc;
    beh[ch] = b;
    snap = trim; sdec = dec; smeta = meta; dv0 = dv_cnt;
    @(negedge clk);
    base = n_eval; pat_base = n_eval;
    start = 1'b1; cal_mode = 1'b1; chan_sel = 2'(ch);
    @(negedge clk); start = 1'b0; cal_mode = 1'b0;
    cyc = 0;
    while (!cal_done && cyc < 3000) begin @(negedge clk); cyc++; end
    chk($sformatf("cal_done_seen ch%0d", ch), cal_done, 1);
    chk($sformatf("cal_trim ch%0d b%0d", ch, b), trim[ch*CB +: CB], exp_trim);
    for (int c = 0; c < NC; c++)
      if (c != ch) chk($sformatf("cal_other_trim ch%0d", c), trim[c*CB +: CB], snap[c*CB +: CB]);
    chk("cal_evals", n_eval - base, CB * CA);
    chk("cal_dec_untouched", {dec, meta}, {sdec, smeta});
    chk("cal_no_dv", dv_cnt - dv0, 0);
    @(negedge clk);
    chk("cal_done_pulse", cal_done, 0);
    chk("cal_busy_clear", busy, 0);
  endtask

  typedef struct {
    int   ch;
    int   b;
    logic edec;
    logic emeta;
    int   elat;
    int   ehi;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int b, ch, cyc, dv0, cd0;
    logic res;
    for (int c = 0; c < NC; c++) beh[c] = 2;

    tbl[0] = '{2, 1, 1'b1, 1'b0, 6, 3};
    tbl[1] = '{0, 0, 1'b0, 1'b0, 6, 3};
    tbl[2] = '{1, 2, 1'b0, 1'b1, 9, 6};
    tbl[3] = '{3, 3, 1'b0, 1'b1, 9, 6};
    tbl[4] = '{3, 1, 1'b1, 1'b0, 6, 3};
    tbl[5] = '{0, 2, 1'b0, 1'b1, 9, 6};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_comp_clk", comp_clk, 0);
    chk("rst_comp_clkb", comp_clkb, 4'hf);
    chk("rst_flags", {busy, dec_valid, dec, meta, cal_done}, 0);
    for (int c = 0; c < NC; c++) chk($sformatf("rst_trim%0d", c), trim[c*CB +: CB], 16);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 6; i++)
      run_normal(tbl[i].ch, tbl[i].b, tbl[i].edec, tbl[i].emeta, tbl[i].elat, tbl[i].ehi);

    // Random normal-mode comparisons; resolve costs sync delay + capture cycle.
    for (int i = 0; i < 16; i++) begin
      ch = int'($urandom_range(NC - 1));
      b  = int'($urandom_range(3));
      res = (b == 0 || b == 1);
      run_normal(ch, b, (b == 1), !res, res ? (1 + 2 + RC + 1) : (MT + RC + 1), res ? 3 : MT);
    end

    // Calibration searches
    thr = 19;
    run_cal(1, 4, cal_model(4));
    thr = 20;
    run_cal(1, 4, 19);
    pat = 64'b1010101;
    run_cal(3, 5, cal_model(5));
    chk("vote_4of7_keeps_msb", trim[3*CB +: CB], 16);
    pat = 64'b0101010;
    run_cal(3, 5, 0);
    run_cal(0, 2, cal_model(2));

    // Reset in the middle of calibration bit 2
    beh[1] = 4; thr = 19;
    dv0 = n_eval;
    @(negedge clk); start = 1'b1; cal_mode = 1'b1; chan_sel = 2'd1;
    @(negedge clk); start = 1'b0; cal_mode = 1'b0;
    cyc = 0;
    while ((n_eval - dv0) < 16 && cyc < 2000) begin @(negedge clk); cyc++; end
    chk("reached_bit2", (n_eval - dv0) >= 16, 1);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) chk($sformatf("midrst_trim%0d", c), trim[c*CB +: CB], 16);
    chk("midrst_comp_clk", comp_clk, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk); rst_n = 1'b1;
    run_normal(1, 1, 1'b1, 1'b0, 6, 3);

    // Starts while busy and on the DONE cycle are dropped
    beh[0] = 1; beh[3] = 0;
    dv0 = dv_cnt; cd0 = cd_cnt;
    @(negedge clk); start = 1'b1; chan_sel = 2'd0; cal_mode = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; chan_sel = 2'd3;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!dec_valid && cyc < 60) begin @(negedge clk); cyc++; end
    chk("busy_run_dv", dec_valid, 1);
    chk("busy_run_dec", dec, 1);
    start = 1'b1; chan_sel = 2'd3; cal_mode = 1'b1;
    @(negedge clk); start = 1'b0; cal_mode = 1'b0;
    chk("done_start_ignored", busy, 0);
    repeat (20) @(negedge clk);
    chk("accepted_dv_count", dv_cnt - dv0, 1);
    chk("no_cal_done", cd_cnt - cd0, 0);
    chk("idle_comp_clk", comp_clk, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
